// File: rtl/tc_cpu_pkg.sv
// Shared types and constants for the CPU-side readback transmitter.
package tc_cpu_pkg;

  localparam int unsigned DefDataW = 128;
  localparam int unsigned DefAddrW = 16;
  localparam int unsigned DefLenW  = 16;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2,
    StDone  = 2'd3
  } state_e;

  // The skid must hold every word that can be in flight when issue stalls.
  function automatic bit rd_lat_legal(input int unsigned rd_lat, input int unsigned skid_depth);
    return (rd_lat >= 1) && (rd_lat <= 3) && (skid_depth >= rd_lat + 1);
  endfunction

endpackage

// File: rtl/isa_readback_128_if.sv
// Command, memory-read and FIFO-write signals of the readback transmitter.
interface isa_readback_128_if
  import tc_cpu_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned LEN_W  = DefLenW
) ();

  logic              start_i;
  logic [ADDR_W-1:0] base_addr_i;
  logic [LEN_W-1:0]  len_i;
  logic              busy_o;
  logic              done_o;
  logic              mem_rden_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_data_i;
  logic [DATA_W-1:0] fifo_din_o;
  logic              fifo_wren_o;
  logic              fifo_full_i;

  // Transmitter side.
  modport master (
    input  start_i, base_addr_i, len_i, mem_data_i, fifo_full_i,
    output busy_o, done_o, mem_rden_o, mem_addr_o, fifo_din_o, fifo_wren_o
  );

  // Command source, memory and FIFO side.
  modport slave (
    output start_i, base_addr_i, len_i, mem_data_i, fifo_full_i,
    input  busy_o, done_o, mem_rden_o, mem_addr_o, fifo_din_o, fifo_wren_o
  );

endinterface

// File: rtl/readback_skid_fifo.sv
// Small synchronous FIFO with first-word-fall-through head and occupancy output.
module readback_skid_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned DataW = 128,
  parameter int unsigned OccW  = $clog2(Depth + 1)
) (
  input  logic             clk_cpu,
  input  logic             rstn,
  input  logic             push_i,
  input  logic [DataW-1:0] push_data_i,
  input  logic             pop_i,
  output logic [DataW-1:0] head_o,
  output logic [OccW-1:0]  occ_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [DataW-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [OccW-1:0]  occ_q;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // Storage is not reset; only the pointers define which entries are live.
  always_ff @(posedge clk_cpu) begin
    if (push_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  // Pointer and occupancy bookkeeping; simultaneous push and pop keep occupancy.
  always_ff @(posedge clk_cpu or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (push_i) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop_i)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      unique case ({push_i, pop_i})
        2'b10:   occ_q <= occ_q + OccW'(1);
        2'b01:   occ_q <= occ_q - OccW'(1);
        default: occ_q <= occ_q;
      endcase
    end
  end

  // Head reads as zero when empty so the FIFO data bus stays quiet.
  always_comb begin
    head_o = '0;
    if (occ_q != '0) head_o = mem_q[rd_ptr_q];
  end

  assign occ_o = occ_q;

endmodule

// File: rtl/isa_readback_128.sv
// Readback transmitter: sweeps a memory range and pushes words into the outbound FIFO.
module isa_readback_128
  import tc_cpu_pkg::*;
#(
  parameter int unsigned DATA_W     = DefDataW,
  parameter int unsigned ADDR_W     = DefAddrW,
  parameter int unsigned LEN_W      = DefLenW,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned SKID_DEPTH = 4
) (
  input logic                clk_cpu,
  input logic                rstn,
  isa_readback_128_if.master bus
);

  localparam int unsigned OccW = $clog2(SKID_DEPTH + 1);

  if (!rd_lat_legal(RD_LAT, SKID_DEPTH)) begin : g_param_check
    $error("isa_readback_128: RD_LAT must be 1..3 and SKID_DEPTH >= RD_LAT+1");
  end

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  remain_q, remain_d;
  logic [RD_LAT-1:0] vpipe_q, vpipe_d;
  logic [OccW-1:0]   occ;
  logic [OccW:0]     inflight;
  logic [OccW:0]     credit_used;
  logic              issue, push, pop, drained;
  logic [DATA_W-1:0] head;

  // Credits: skid occupancy plus reads still travelling through the memory.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) inflight = inflight + (OccW + 1)'(vpipe_q[i]);
    credit_used = {1'b0, occ} + inflight;
    issue       = (state_q == StRun) && (credit_used < (OccW + 1)'(SKID_DEPTH));
    push        = vpipe_q[RD_LAT-1];
    pop         = (occ != '0) && !bus.fifo_full_i;
    vpipe_d     = vpipe_q << 1;
    vpipe_d[0]  = issue;
    // Look ahead one edge so done follows the final FIFO write directly.
    drained     = (vpipe_d == '0) &&
                  (((occ == '0) && !push) || ((occ == OccW'(1)) && pop && !push));
  end

  // Next-state logic for the sweep sequencer.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    remain_d = remain_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start_i) begin
          if (bus.len_i != '0) begin
            state_d  = StRun;
            addr_d   = bus.base_addr_i;
            remain_d = bus.len_i;
          end else begin
            state_d = StDone;
          end
        end
      end
      StRun: begin
        if (issue) begin
          addr_d   = addr_q + ADDR_W'(1);
          remain_d = remain_q - LEN_W'(1);
          if (remain_q == LEN_W'(1)) state_d = StDrain;
        end
      end
      StDrain: begin
        if (drained) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Sequencer state, address/length counters and read-valid pipe.
  always_ff @(posedge clk_cpu or negedge rstn) begin
    if (!rstn) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      remain_q <= '0;
      vpipe_q  <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      remain_q <= remain_d;
      vpipe_q  <= vpipe_d;
    end
  end

  readback_skid_fifo #(
    .Depth (SKID_DEPTH),
    .DataW (DATA_W),
    .OccW  (OccW)
  ) u_skid (
    .clk_cpu     (clk_cpu),
    .rstn        (rstn),
    .push_i      (push),
    .push_data_i (bus.mem_data_i),
    .pop_i       (pop),
    .head_o      (head),
    .occ_o       (occ)
  );

  assign bus.busy_o      = (state_q != StIdle);
  assign bus.done_o      = (state_q == StDone);
  assign bus.mem_rden_o  = issue;
  assign bus.mem_addr_o  = addr_q;
  assign bus.fifo_wren_o = pop;
  assign bus.fifo_din_o  = head;

endmodule

// File: doc/isa_readback_128.md
Name: isa_readback_128

Overview:
- CPU-side transmitter for the host readback path, the mirror of the inbound instruction buffer.
- On a start command it sweeps a range of CPU-side 128-bit memory words (16-bit word address) with fixed read latency.
- It pushes each word, in address order, into the write port of the outbound clock-crossing FIFO, which is external vendor IP written in clk_cpu.
- The FIFO's full flag provides backpressure. A small credit-managed skid buffer absorbs words still in flight from memory.

Parameters:
- DATA_W, 128, memory/FIFO data width.
- ADDR_W, 16, memory word address width.
- LEN_W, 16, transfer length counter width.
- RD_LAT, 1, memory read latency in cycles; legal range 1..3.
- SKID_DEPTH, 4, skid buffer entries; must be >= RD_LAT+1. Must be >= RD_LAT+2 for sustained 1 word/cycle.

Ports:
- clk_cpu  in  1  CPU clock.
- rstn  in  1  reset.
- start_i  in  1  1-cycle command pulse; sampled only in IDLE.
- base_addr_i  in  ADDR_W  first word address; sampled with start_i.
- len_i  in  LEN_W  number of words; sampled with start_i; 0 is legal.
- busy_o  out  1  high whenever state != IDLE.
- done_o  out  1  1-cycle pulse at end of transfer.
- mem_rden_o  out  1  memory read strobe.
- mem_addr_o  out  ADDR_W  memory read address, valid with mem_rden_o.
- mem_data_i  in  DATA_W  read data, valid RD_LAT cycles after mem_rden_o.
- fifo_din_o  out  DATA_W  FIFO write data (skid head).
- fifo_wren_o  out  1  FIFO write enable.
- fifo_full_i  in  1  FIFO full flag.

Behaviour:
- Reset: rstn asynchronous, active-low; clock clk_cpu.
  - All state, counters, skid pointers and the RD_LAT valid pipe clear.
  - Outputs during reset: busy_o=0, done_o=0, mem_rden_o=0, mem_addr_o=0, fifo_wren_o=0, fifo_din_o=0.
  - Reset mid-transfer discards in-flight and buffered words. No done_o is produced.
- States: IDLE, RUN, DRAIN, DONE.
  - IDLE -> RUN on start_i with len_i != 0. addr_r <= base_addr_i, remain_r <= len_i.
  - IDLE -> DONE on start_i with len_i == 0. No reads, no writes.
  - RUN -> DRAIN in the cycle the last read issues (remain_r goes to 0).
  - DRAIN -> DONE when inflight==0, the skid is empty, and no write is pending.
  - DONE -> IDLE unconditionally. done_o=1 only in DONE.
  - start_i outside IDLE is ignored.
- Issue rule:
  - mem_rden_o = (state==RUN) && (occ + inflight < SKID_DEPTH). Combinational from registered state.
  - occ is registered skid occupancy. inflight is the popcount of the RD_LAT-deep valid shift pipe.
  - Each issue: addr_r increments modulo 2^ADDR_W (0xFFFF wraps to 0x0000); remain_r decrements.
  - mem_addr_o = addr_r.
- Capture: when the valid pipe output is 1, mem_data_i is written into the skid tail at that clock edge. Overflow is impossible by the credit rule; the bench asserts this.
- Drain:
  - fifo_wren_o = (occ != 0) && !fifo_full_i. fifo_din_o = skid head (0 when empty).
  - A write pops the head at the same edge.
  - Push and pop in the same cycle leave occ unchanged.
- Latency: start_i in cycle 0 -> first mem_rden_o in cycle 1 -> first fifo_wren_o in cycle 2+RD_LAT, if not full.
- Completion: done_o is asserted in the cycle after the final fifo_wren_o.
- Backpressure: while fifo_full_i=1, fifo_wren_o=0. Issue continues until credits are exhausted, then stalls. No word is lost, duplicated or reordered.

Decomposition:
- Shared package (tc_cpu_pkg): state encoding constants (IDLE/RUN/DRAIN/DONE), DATA_W/ADDR_W defaults, RD_LAT legality check.
- One sub-module: readback_skid_fifo, a synchronous SKID_DEPTH x DATA_W FIFO with occ output, push/pop, and first-word-fall-through head.

Test Plan:
- Basic transfer: RD_LAT=1, base=0x0010, len=4, memory word n = {112'h0, n[15:0]}, full held 0.
  - mem_rden_o in cycles 1-4 with addr 0x10..0x13.
  - fifo_wren_o in cycles 3-6 with data 0x10..0x13.
  - done_o in cycle 7 only; busy_o high cycles 1-7.
- Zero length: len=0 -> no mem_rden_o, no fifo_wren_o; done_o in cycle 1; busy_o high cycle 1 only.
- Backpressure: len=16, fifo_full_i=1 from cycle 3 to cycle 12.
  - Issues stop once occ+inflight reaches 4.
  - All 16 words arrive in order after full drops; exactly 16 writes total.
- Address wrap: base=0xFFFE, len=4 -> addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001; data in the same order.
- Reset mid-transfer: rstn low for 1 cycle during RUN of len=8 at RD_LAT=3.
  - All outputs go to 0 immediately; no further writes; no done_o.
  - A new start after reset behaves as in the basic-transfer scenario.
- Throughput and ignored start: RD_LAT=2, len=32, full=0 -> 32 consecutive fifo_wren_o cycles. A start_i pulse mid-transfer is ignored.
